multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences the shared datapath
// over several cycles per instruction, stalls on MemReady, traps on unknown opcodes.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_LUI      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] r_state;
  logic [3:0] w_state_next;
  logic       w_sub_en;
  logic [2:0] w_funct_alu;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Subtract only for register-register ops; addi with Instr[30] set stays add.
  assign w_sub_en = (r_state == S_EXECR) && funct7b5;

  always_comb begin
    w_funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  w_funct_alu = w_sub_en ? ALU_SUB : ALU_ADD;
      3'b010:  w_funct_alu = ALU_SLT;
      3'b110:  w_funct_alu = ALU_OR;
      3'b111:  w_funct_alu = ALU_AND;
      default: w_funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_RTYPE:          w_state_next = S_EXECR;
          OP_ITYPE:          w_state_next = S_EXECI;
          OP_BEQ:            w_state_next = S_BEQ;
          OP_LUI:            w_state_next = S_LUI;
          default:           w_state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_state_next = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_state_next = S_FETCH;
      S_MEMWRITE: w_state_next = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_state_next = S_ALUWB;
      S_EXECI:    w_state_next = S_ALUWB;
      S_ALUWB:    w_state_next = S_FETCH;
      S_BEQ:      w_state_next = S_FETCH;
      S_LUI:      w_state_next = S_FETCH;
      S_TRAP:     w_state_next = S_TRAP;
      default:    w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      // Branch target (OldPC + B-immediate) is parked in ALUOut here.
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b11;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_LOAD) ? 2'b10 : 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_funct_alu;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = 2'b10;
        ALUControl = w_funct_alu;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = Zero;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      S_TRAP:  Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its list
// of phases and every cycle's outputs are compared against the phase's expected values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int n_vec = 0;
  int n_err = 0;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_LUI, P_TRAP} phase_t;

  phase_t phases[$];
  int     idx;
  int     trap_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Illegal(Illegal)
  );

  logic [16:0] w_dut_vec;
  assign w_dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                      ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s op=%b f3=%b f7b5=%b got=%h exp=%h @%0t",
               tag, op, funct3, funct7b5, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] funct_alu(input logic sub_ok);
    case (funct3)
      3'b000:  return (sub_ok && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [16:0] exp_vec(input phase_t ph);
    logic       pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm = 0;
    logic [2:0] alu = 0;
    case (ph)
      P_FETCH:    begin sb = 2; rs = 2; pcw = MemReady; irw = MemReady; end
      P_DECODE:   begin sa = 1; sb = 1; imm = 3; end
      P_MEMADR:   begin sa = 2; sb = 1; imm = (op == 7'b0000011) ? 2'd2 : 2'd1; end
      P_MEMREAD:  adr = 1;
      P_MEMWB:    begin rs = 1; rw = 1; end
      P_MEMWRITE: begin adr = 1; mw = 1; end
      P_EXECR:    begin sa = 2; alu = funct_alu(1'b1); end
      P_EXECI:    begin sa = 2; sb = 1; imm = 2; alu = funct_alu(1'b0); end
      P_ALUWB:    rw = 1;
      P_BEQ:      begin sa = 2; alu = 3'b001; pcw = Zero; end
      P_LUI:      begin rs = 3; rw = 1; end
      P_TRAP:     ill = 1;
      default:    ;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  // Pick a new instruction and lay out the phases it should walk through.
  task automatic new_instr();
    int k;
    logic [6:0] o;
    k = $urandom_range(0, 6);
    funct3   = 3'($urandom_range(0, 7));
    funct7b5 = 1'($urandom_range(0, 1));
    phases = {P_FETCH, P_DECODE};
    case (k)
      0: begin o = 7'b0000011; phases.push_back(P_MEMADR); phases.push_back(P_MEMREAD); phases.push_back(P_MEMWB); end
      1: begin o = 7'b0100011; phases.push_back(P_MEMADR); phases.push_back(P_MEMWRITE); end
      2: begin o = 7'b0110011; phases.push_back(P_EXECR); phases.push_back(P_ALUWB); end
      3: begin o = 7'b0010011; phases.push_back(P_EXECI); phases.push_back(P_ALUWB); end
      4: begin o = 7'b1100011; phases.push_back(P_BEQ); end
      5: begin o = 7'b0110111; phases.push_back(P_LUI); end
      default: begin
        o = 7'b1111111;
        if ($urandom_range(0, 1) == 1) begin
          do o = 7'($urandom_range(0, 127));
          while (o inside {7'b0000011, 7'b0100011, 7'b0110011,
                           7'b0010011, 7'b1100011, 7'b0110111});
        end
        phases.push_back(P_TRAP);
      end
    endcase
    op = o;
    idx = 0;
    trap_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
    @(posedge clk);
    new_instr();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      #1;
      if (phases[idx] == P_TRAP && trap_cnt >= 10)
        reset = ($urandom_range(0, 3) == 0);
      else if (phases[idx] == P_TRAP)
        reset = 1'b0;
      else
        reset = ($urandom_range(0, 59) == 0);
      MemReady = ($urandom_range(0, 9) < 7);
      Zero     = 1'($urandom_range(0, 1));
      #3;
      check_eq($sformatf("outs_%s", phases[idx].name()), 32'(w_dut_vec), 32'(exp_vec(phases[idx])));
      check_eq("one_write_en", 32'($countones({RegWrite, MemWrite, PCWrite}) <= 1), 32'd1);
      @(posedge clk);
      if (reset) begin
        new_instr();
      end else if (phases[idx] == P_TRAP) begin
        trap_cnt++;
      end else if (!((phases[idx] inside {P_FETCH, P_MEMREAD, P_MEMWRITE}) && !MemReady)) begin
        idx++;
        if (idx == phases.size()) new_instr();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
